// File: rtl/or_window_accum_if.sv
// Valid/ready input stream and single-register output stream of the windowed OR accumulator.
interface or_window_accum_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH_W  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_chan;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_chan;
  logic [WIDTH-1:0] out_data;
  logic             out_any;

  modport master (
    output in_valid, in_chan, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_chan, out_data, out_any
  );

  modport slave (
    input  in_valid, in_chan, in_op, in_data, out_ready,
    output in_ready, out_valid, out_chan, out_data, out_any
  );
endinterface

// File: rtl/or_window_accum.sv
// Per-channel OR accumulators; each emits its OR-reduced word after WINDOW OR/LOAD beats.
module or_window_accum #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WINDOW   = 8,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  or_window_accum_if.slave    bus,
  output logic [CHANNELS-1:0] chan_any,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  localparam logic [1:0] OP_OR    = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  logic [WIDTH-1:0] acc [CHANNELS];
  logic [CNT_W-1:0] cnt [CHANNELS];

  logic             hit;
  logic             in_range;
  logic             is_acc;
  logic             emit;
  logic [WIDTH-1:0] sel_acc;
  logic [CNT_W-1:0] sel_cnt;
  logic [WIDTH-1:0] next_word;
  logic [CNT_W-1:0] next_cnt;

  // The single output register frees up in the same cycle it is consumed.
  assign bus.in_ready = ~bus.out_valid | bus.out_ready;

  // Decode the incoming beat against the addressed channel's current state.
  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_chan == CH_W'(c)) begin
        sel_acc = acc[c];
        sel_cnt = cnt[c];
      end
    end
    hit       = bus.in_valid & bus.in_ready;
    in_range  = 32'(bus.in_chan) < CHANNELS;
    is_acc    = (bus.in_op == OP_OR) || (bus.in_op == OP_LOAD);
    next_word = (bus.in_op == OP_LOAD) ? bus.in_data : (sel_acc | bus.in_data);
    next_cnt  = (bus.in_op == OP_LOAD) ? CNT_W'(1) : (sel_cnt + CNT_W'(1));
    emit      = hit & in_range & is_acc & (next_cnt == CNT_W'(WINDOW));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.out_chan  <= '0;
      bus.out_data  <= '0;
      bus.out_any   <= 1'b0;
      err           <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (hit && in_range && (bus.in_chan == CH_W'(c))) begin
          case (bus.in_op)
            OP_OR, OP_LOAD: begin
              // A completing beat hands its word to the output and restarts the window.
              if (emit) begin
                acc[c] <= '0;
                cnt[c] <= '0;
              end else begin
                acc[c] <= next_word;
                cnt[c] <= next_cnt;
              end
            end
            OP_CLEAR: begin
              acc[c] <= '0;
              cnt[c] <= '0;
            end
            default: ;
          endcase
        end
      end

      if (hit && !in_range) begin
        err <= 1'b1;
      end

      // emit implies in_ready, so a held result is never overwritten unconsumed.
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_chan  <= bus.in_chan;
        bus.out_data  <= next_word;
        bus.out_any   <= |next_word;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    chan_any = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_any[c] = |acc[c];
    end
  end

endmodule

// File: tb/tb_or_window_accum.sv
// Directed checks of or_window_accum: default instance (4 ch, WINDOW=8) and a 3 ch, WINDOW=1 instance.
module tb_or_window_accum;

  logic clk;
  logic reset;

  or_window_accum_if #(.WIDTH(16), .CH_W(2)) a ();
  or_window_accum_if #(.WIDTH(16), .CH_W(2)) b ();

  logic [3:0] a_chan_any;
  logic       a_err;
  logic [2:0] b_chan_any;
  logic       b_err;

  or_window_accum #(.WIDTH(16), .CHANNELS(4), .WINDOW(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (a.slave),
    .chan_any (a_chan_any),
    .err      (a_err)
  );

  or_window_accum #(.WIDTH(16), .CHANNELS(3), .WINDOW(1)) u_w1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (b.slave),
    .chan_any (b_chan_any),
    .err      (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  chan;
    logic [15:0] data;
    logic        exp_valid;
    logic [1:0]  exp_chan;
    logic [15:0] exp_data;
    logic        exp_any;
    logic [3:0]  exp_cany;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d,
                     input logic ev, input logic [1:0] ec, input logic [15:0] ed,
                     input logic ea, input logic [3:0] ecany);
    vec_t v;
    v.op = op; v.chan = ch; v.data = d;
    v.exp_valid = ev; v.exp_chan = ec; v.exp_data = ed; v.exp_any = ea; v.exp_cany = ecany;
    vecs.push_back(v);
  endtask

  // One accepted-or-offered beat on instance a; returns 1 time unit after the edge.
  task automatic beat_a(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
    @(negedge clk);
    a.in_valid = 1'b1; a.in_op = op; a.in_chan = ch; a.in_data = d;
    @(posedge clk);
    #1;
    a.in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
    @(negedge clk);
    b.in_valid = 1'b1; b.in_op = op; b.in_chan = ch; b.in_data = d;
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
  endtask

  task automatic idle;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  int          n_emit;
  logic [15:0] last_data;

  initial begin
    a.in_valid = 1'b0; a.in_op = 2'b11; a.in_chan = '0; a.in_data = '0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_op = 2'b11; b.in_chan = '0; b.in_data = '0; b.out_ready = 1'b1;

    // ch1 OR window, interleaved ch0/ch2, ch3 CLEAR then LOAD
    add(2'b00, 2'd1, 16'h0001, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0010);
    add(2'b00, 2'd1, 16'h0002, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0010);
    add(2'b00, 2'd1, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0010);
    add(2'b00, 2'd1, 16'h8000, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++)
      add(2'b00, 2'd1, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0010);
    add(2'b00, 2'd1, 16'h0000, 1'b1, 2'd1, 16'h8003, 1'b1, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      add(2'b00, 2'd0, 16'h0000, (i == 7), 2'd0, 16'h0000, 1'b0, (i == 0) ? 4'b0000 : 4'b0100);
      add(2'b00, 2'd2, 16'h00F0, (i == 7), 2'd2, 16'h00F0, 1'b1, (i == 7) ? 4'b0000 : 4'b0100);
    end
    for (int i = 0; i < 3; i++)
      add(2'b00, 2'd3, 16'h00FF, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b1000);
    add(2'b10, 2'd3, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0000);
    add(2'b01, 2'd3, 16'h1000, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b1000);
    for (int i = 0; i < 6; i++)
      add(2'b00, 2'd3, 16'h0001, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b1000);
    add(2'b00, 2'd3, 16'h0001, 1'b1, 2'd3, 16'h1001, 1'b1, 4'b0000);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_out_chan",  32'(a.out_chan),  32'd0);
    chk("rst_out_data",  32'(a.out_data),  32'd0);
    chk("rst_out_any",   32'(a.out_any),   32'd0);
    chk("rst_chan_any",  32'(a_chan_any),  32'd0);
    chk("rst_err",       32'(a_err),       32'd0);
    chk("rst_in_ready",  32'(a.in_ready),  32'd1);
    chk("rst_w1_err",    32'(b_err),       32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      beat_a(vecs[i].op, vecs[i].chan, vecs[i].data);
      chk($sformatf("vec%0d_valid", i), 32'(a.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_chan", i), 32'(a.out_chan), 32'(vecs[i].exp_chan));
        chk($sformatf("vec%0d_data", i), 32'(a.out_data), 32'(vecs[i].exp_data));
        chk($sformatf("vec%0d_any", i),  32'(a.out_any),  32'(vecs[i].exp_any));
      end
      chk($sformatf("vec%0d_chan_any", i), 32'(a_chan_any), 32'(vecs[i].exp_cany));
    end
    idle();
    chk("after_vec_valid", 32'(a.out_valid), 32'd0);

    // Backpressure: ch2 primed with 7 beats, ch1 result held, then completing ch2 beat on release
    for (int i = 0; i < 7; i++) beat_a(2'b00, 2'd2, 16'h0300);
    chk("bp_ch2_primed", 32'(a.out_valid), 32'd0);
    @(negedge clk);
    a.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat_a(2'b00, 2'd1, 16'h0A0A);
    chk("bp_held_valid", 32'(a.out_valid), 32'd1);
    chk("bp_held_data",  32'(a.out_data),  32'h0A0A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a.in_valid = 1'b1; a.in_op = 2'b00; a.in_chan = 2'd2; a.in_data = 16'h0040;
      #1;
      chk($sformatf("bp_in_ready%0d", i), 32'(a.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid%0d", i), 32'(a.out_valid), 32'd1);
      chk($sformatf("bp_data%0d", i),  32'(a.out_data),  32'h0A0A);
      chk($sformatf("bp_chan%0d", i),  32'(a.out_chan),  32'd1);
    end
    @(negedge clk);
    a.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a.in_ready), 32'd1);
    @(posedge clk);
    #1;
    a.in_valid = 1'b0;
    chk("bp_reload_valid", 32'(a.out_valid), 32'd1);
    chk("bp_reload_chan",  32'(a.out_chan),  32'd2);
    chk("bp_reload_data",  32'(a.out_data),  32'h0340);
    chk("bp_reload_any",   32'(a.out_any),   32'd1);
    idle();
    chk("bp_drain_valid", 32'(a.out_valid), 32'd0);

    // WINDOW=1 instance: out-of-range channel, then immediate emission
    beat_b(2'b00, 2'd3, 16'h0007);
    chk("w1_err_set",   32'(b_err),       32'd1);
    chk("w1_oor_valid", 32'(b.out_valid), 32'd0);
    chk("w1_oor_cany",  32'(b_chan_any),  32'd0);
    beat_b(2'b00, 2'd2, 16'h0005);
    chk("w1_emit_valid", 32'(b.out_valid), 32'd1);
    chk("w1_emit_chan",  32'(b.out_chan),  32'd2);
    chk("w1_emit_data",  32'(b.out_data),  32'h0005);
    chk("w1_err_hold",   32'(b_err),       32'd1);
    idle();
    chk("w1_err_hold2",  32'(b_err),       32'd1);
    chk("w1_drain",      32'(b.out_valid), 32'd0);

    // Async reset mid-window, then with a result pending
    for (int i = 0; i < 5; i++) beat_a(2'b00, 2'd0, 16'h0011);
    chk("mid_cany", 32'(a_chan_any), 32'b0001);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(a.out_valid), 32'd0);
    chk("mid_rst_cany",  32'(a_chan_any),  32'd0);
    chk("mid_rst_w1err", 32'(b_err),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    a.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat_a(2'b00, 2'd1, 16'h0001);
    chk("pend_valid", 32'(a.out_valid), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("pend_rst_valid", 32'(a.out_valid), 32'd0);
    chk("pend_rst_data",  32'(a.out_data),  32'd0);
    chk("pend_rst_cany",  32'(a_chan_any),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    a.out_ready = 1'b1;
    n_emit = 0;
    last_data = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) beat_a(2'b00, 2'd0, 16'h0001);
      else idle();
      if (a.out_valid) begin
        n_emit++;
        last_data = a.out_data;
      end
    end
    chk("post_rst_emits", 32'(n_emit),    32'd1);
    chk("post_rst_data",  32'(last_data), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
